// File: rtl/serial_adder_if.sv
// ---------------------------------------------------------------------------
// serial_adder_if
// Request/result bundle between a requester and the bit-serial adder.
//   master : requester side  (drives start/a/b[/sub], samples results)
//   slave  : adder side      (samples start/a/b[/sub], drives results)
// Signals
//   start  request, honoured only while ready=1
//   a, b   operands, captured on an accepted start
//   sub    (only with SERIAL_ADDER_SUB_EN) 1 = compute a-b
//   ready  adder idle, next start is accepted
//   busy   bits being computed
//   done   one-cycle pulse, sum/cout just updated
//   sum    last completed result
//   cout   carry out of MSB (no-borrow flag in subtract mode)
// Optional feature macro: SERIAL_ADDER_SUB_EN
// ---------------------------------------------------------------------------
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, sub, input ready, busy, done, sum, cout);
  modport slave  (input start, a, b, sub, output ready, busy, done, sum, cout);
`else
  modport master (output start, a, b, input ready, busy, done, sum, cout);
  modport slave  (input start, a, b, output ready, busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
// Bit-serial adder: one full-add bit per cycle, LSB first, over WIDTH cycles.
// Ports
//   clk   rising-edge clock
//   rst   asynchronous reset, active-high
//   bus   serial_adder_if.slave (start/a/b[/sub] in; ready/busy/done/sum/cout out)
// Timing: start accepted at edge N -> done high in the cycle after edge
// N+WIDTH -> ready high one cycle later (one op per WIDTH+2 cycles).
// Optional feature macro: SERIAL_ADDER_SUB_EN adds bus.sub; sub=1 computes
// a-b mod 2^WIDTH with cout=1 meaning no borrow.
// ---------------------------------------------------------------------------
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-1:0]   r_r_sr;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ready;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;

  // Single-bit datapath: two cascaded half-add stages plus the carry flop.
  logic             w_p;
  logic             w_g;
  logic             w_s;
  logic             w_carry_nxt;
  logic [WIDTH-1:0] w_r_nxt;
  logic             w_last;

  assign w_p         = r_a_sr[0] ^ r_b_sr[0];
  assign w_g         = r_a_sr[0] & r_b_sr[0];
  assign w_s         = w_p ^ r_carry;
  assign w_carry_nxt = w_g | (w_p & r_carry);
  assign w_r_nxt     = {w_s, r_r_sr[WIDTH-1:1]};
  assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));

  // NOTE: every register here is a flop updated with non-blocking assignments
  // so all next-state values are computed from the same pre-edge snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_r_sr  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          // ready is 1 throughout IDLE, so start alone qualifies acceptance.
          if (bus.start) begin
            r_a_sr  <= bus.a;
`ifdef SERIAL_ADDER_SUB_EN
            // Two's-complement subtract: invert b and inject carry-in of 1.
            r_b_sr  <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub;
`else
            r_b_sr  <= bus.b;
            r_carry <= 1'b0;
`endif
            r_r_sr  <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_ADD;
          end
        end

        S_ADD: begin
          r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_r_sr  <= w_r_nxt;
          r_carry <= w_carry_nxt;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            // Results publish only here, so sum/cout hold through ADD.
            r_sum   <= w_r_nxt;
            r_cout  <= w_carry_nxt;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ready = r_ready;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.sum   = r_sum;
  assign bus.cout  = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
// Scoreboard bench: the driver predicts each accepted op's result and done
// cycle and queues it; the monitor checks every cycle's outputs against it.
// Define SERIAL_ADDER_SUB_EN for both RTL and bench to exercise subtract.
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int           cyc;     // cycle index in which done must be high
  } exp_t;

  logic clk;
  logic rst;
  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  exp_t         q[$];
  int           m_idle_from = 0;   // first cycle index in which ready=1
  logic [W-1:0] m_sum  = '0;
  logic         m_cout = 1'b0;
  int           n_checks = 0;
  int           n_pass   = 0;
  int           n_ops    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input int done_cyc);
    exp_t e;
    int unsigned ia = a;
    int unsigned ib = b;
    if (s) begin
      e.sum  = W'((ia + (1 << W) - ib) % (1 << W));
      e.cout = (ia >= ib);
    end else begin
      e.sum  = W'((ia + ib) % (1 << W));
      e.cout = ((ia + ib) >= (1 << W));
    end
    e.cyc = done_cyc;
    return e;
  endfunction

  // One cycle of stimulus, applied just after the falling edge.
  task automatic step(input logic st, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic sv);
    logic s_eff;
    @(negedge clk);
    #1;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = sv;
    s_eff   = sv;
`else
    s_eff   = 1'b0 & sv;
`endif
    bus.start = st;
    bus.a     = av;
    bus.b     = bv;
    if (st && cyc >= m_idle_from) begin
      q.push_back(model(av, bv, s_eff, cyc + 1 + W));
      m_idle_from = cyc + 2 + W;
      n_ops++;
    end
  endtask

  task automatic idle_step();
    step(1'b0, W'($urandom), W'($urandom), 1'($urandom));
  endtask

  task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    while (cyc + 1 < m_idle_from) idle_step();
    step(1'b1, av, bv, sv);
  endtask

  // Monitor: compares every cycle against the scoreboard, on the falling edge.
  initial begin
    forever begin
      logic exp_done;
      logic exp_busy;
      @(negedge clk);
      exp_done = (q.size() > 0) && (q[0].cyc == cyc);
      exp_busy = (q.size() > 0) && (cyc < q[0].cyc) && (cyc >= q[0].cyc - W);
      check("done",  32'(bus.done),  32'(exp_done));
      check("busy",  32'(bus.busy),  32'(exp_busy));
      check("ready", 32'(bus.ready), 32'(cyc >= m_idle_from));
      if (exp_done) begin
        exp_t e;
        e = q.pop_front();
        m_sum  = e.sum;
        m_cout = e.cout;
      end
      check("sum",  32'(bus.sum),  32'(m_sum));
      check("cout", 32'(bus.cout), 32'(m_cout));
    end
  end

  initial begin
    int guard;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = 1'b0;
`endif
    #2;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_busy",  32'(bus.busy),  32'd0);
    check("rst_done",  32'(bus.done),  32'd0);
    check("rst_sum",   32'(bus.sum),   32'd0);
    check("rst_cout",  32'(bus.cout),  32'd0);
    #10;
    rst = 1'b0;

    // Directed operands, including carry-out boundaries.
    op(8'h35, 8'h4A, 1'b0);
    op(8'hFF, 8'h01, 1'b0);
    op(8'hFF, 8'hFF, 1'b0);
    op(8'h00, 8'h00, 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
    op(8'h10, 8'h01, 1'b1);
    op(8'h00, 8'h01, 1'b1);
    op(8'h5A, 8'h5A, 1'b1);
`endif

    // start held high with changing operands: only idle-cycle requests count.
    repeat (40) step(1'b1, W'($urandom), W'($urandom), 1'($urandom));

    // Asynchronous reset in the middle of an add.
    op(8'hA5, 8'h3C, 1'b0);
    repeat (4) idle_step();
    @(posedge clk);
    #3;
    rst = 1'b1;
    bus.start = 1'b0;
    #1;
    check("mid_rst_ready", 32'(bus.ready), 32'd1);
    check("mid_rst_busy",  32'(bus.busy),  32'd0);
    check("mid_rst_done",  32'(bus.done),  32'd0);
    check("mid_rst_sum",   32'(bus.sum),   32'd0);
    check("mid_rst_cout",  32'(bus.cout),  32'd0);
    q.delete();
    m_sum       = '0;
    m_cout      = 1'b0;
    m_idle_from = 0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    op(8'h35, 8'h4A, 1'b0);

    // Randomized traffic, start asserted most cycles.
    guard = 0;
    n_ops = 0;
    while (n_ops < 1000 && guard < 30000) begin
      step($urandom_range(0, 3) != 0, W'($urandom), W'($urandom), 1'($urandom));
      guard++;
    end
    check("random_op_count", 32'(n_ops), 32'd1000);

    repeat (W + 4) idle_step();
    check("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
